// File: rtl/unidade_controle.sv
// unidade_controle: main Moore control FSM of the multicycle RISC-V core.
// Define CTRL_JAL_EN to decode jal (opcode 1101111); otherwise it is illegal.
module unidade_controle #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [1:0] ULAOp,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_ILLEGAL  = 4'd10,
        S_JAL      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t state_q, state_d, cur;
    logic   illegal_q, illegal_d;
    logic   pc_update, branch, mem_write, ir_write, reg_write;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef CTRL_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            // Anything but sw reads: a read has no side effect.
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
`ifdef CTRL_JAL_EN
            S_JAL:      state_d = S_ALUWB;
`endif
            default:    state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= state_t'(RESET_STATE);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // While in reset, show FETCH so the datapath sees a benign command.
    always_comb begin
        cur       = rst_n ? state_q : S_FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ULAOp     = 2'b00;
        case (cur)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = mem_ready;
                pc_update = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ULAOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ULAOp   = 2'b11;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ULAOp   = 2'b01;
                branch  = 1'b1;
            end
`ifdef CTRL_JAL_EN
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign PCWrite  = rst_n & (pc_update | (branch & zero));
    assign IRWrite  = rst_n & ir_write;
    assign MemWrite = rst_n & mem_write;
    assign RegWrite = rst_n & reg_write;
    assign illegal  = rst_n & illegal_q;
    assign state_o  = cur;

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Main control unit of the multicycle RISC-V core.
- Moore FSM sequencing each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath mux selects, write enables and the 2-bit ULAOp command consumed by the ALU-control decoder.
- Sits between the instruction register (opcode), the ALU Zero flag, the memory ready handshake and the datapath.

Parameters:
- RESET_STATE, 4'd0, FSM encoding loaded on reset (FETCH). Must stay 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  7  instruction opcode field
- zero  in  1  ALU Zero flag, combinational, same cycle
- mem_ready  in  1  memory completes access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0: address from PC; 1: address from ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALU result
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 immediate, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; decoded combinationally from op
- RegWrite  out  1  register file write enable
- ULAOp  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- illegal  out  1  sticky unsupported-opcode flag
- state_o  out  4  current state, for debug

Behaviour:
- Reset: state <= FETCH and illegal <= 0 on a clk edge with rst_n=0.
  - While rst_n=0, PCWrite/IRWrite/MemWrite/RegWrite are forced to 0.
  - All other outputs take their FETCH values.
- Outputs are Moore, decoded from state. Unlisted outputs are 0. PCWrite = PCUpdate | (Branch & zero).
- Supported opcodes: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-type ALU, 1100011 beq.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ULAOp=00, ResultSrc=10.
  - IRWrite=mem_ready and PCUpdate=mem_ready.
  - Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ULAOp=00 (branch target precompute).
  - lw/sw -> MEMADR; R -> EXECR; I -> EXECI; beq -> BEQ.
  - Any other opcode -> ILLEGAL.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ULAOp=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in the state. Holds until mem_ready=1, then -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ULAOp=10 -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ULAOp=11 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ULAOp=01, ResultSrc=00, Branch=1 -> FETCH. PCWrite equals zero in that cycle.
- ILLEGAL: all enables 0, illegal=1, self-loop. Left only by reset.
- Cycle counts with mem_ready tied high: lw 5, sw 4, R/I 4, beq 3.
- op is only sampled in DECODE and MEMADR. Changes in op during other states have no effect.
- Unused state encodings -> FETCH on the next edge.
- Reset mid-instruction: the in-flight instruction is abandoned. No write enable may assert in the reset cycle.

Optional Feature:
- Macro CTRL_JAL_EN.
- When defined: opcode 1101111 (jal) is decoded in DECODE -> JAL.
  - JAL state: ALUSrcA=01, ALUSrcB=10, ULAOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - Result: rd = OldPC+4 and PC = jump target; 4 cycles.
- When undefined: 1101111 is treated as illegal (DECODE -> ILLEGAL).

Test Plan:
- rst_n=0 for 2 cycles with mem_ready=1 -> PCWrite=IRWrite=RegWrite=MemWrite=0, state_o=0. After release, first cycle shows IRWrite=1, PCWrite=1.
- op=0110011, mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB. ULAOp=10 in EXECR; RegWrite=1 only in ALUWB.
- op=0000011 with mem_ready low for 3 cycles in MEMREAD -> state held 3 extra cycles, then MEMWB with ResultSrc=01, RegWrite=1.
- op=1100011: zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0. ULAOp=01 in both cases; next state FETCH.
- op=1111111 -> ILLEGAL, illegal=1. No enables for 10 cycles. Reset returns to FETCH with illegal=0.
- op=1101111 -> JAL path of 4 cycles if CTRL_JAL_EN is defined; ILLEGAL otherwise.
